// File: rtl/core_pkg.sv
// Shared constants and payload types for the core pipeline stages.
// Holds write-back select encodings, the MEM-stage FSM state type and the MEM/WB payload.
package core_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned SEL_W = 2;

    localparam logic [SEL_W-1:0] WB_ALU = 2'd0;
    localparam logic [SEL_W-1:0] WB_MEM = 2'd1;
    localparam logic [SEL_W-1:0] WB_TPU = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } mem_state_t;

    typedef struct packed {
        logic [XLEN-1:0]  data;
        logic             we;
        logic [REG_W-1:0] dst;
    } mem_wb_t;

    // Write-back value for ops that do not touch data memory.
    function automatic logic [XLEN-1:0] alu_wb_data(
        input logic [SEL_W-1:0] sel,
        input logic [XLEN-1:0]  alu,
        input logic [XLEN-1:0]  tpu
    );
        logic [XLEN-1:0] res;
        case (sel)
            WB_ALU:  res = alu;
            WB_TPU:  res = tpu;
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB payload register: stall freezes it, load captures a payload, bubble clears it.
// Stall has priority over both load and bubble.
module mem_wb_reg
    import core_pkg::*;
(
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    stall_i,
    input  logic    load_i,
    input  logic    bubble_i,
    input  mem_wb_t d_i,
    output mem_wb_t q_o
);

    mem_wb_t r_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_q <= '0;
        end else if (!stall_i) begin
            if (load_i) begin
                r_q <= d_i;
            end else if (bubble_i) begin
                r_q <= '0;
            end
        end
    end

    assign q_o = r_q;

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: runs the req/gnt/rvalid data-memory handshake for lw/sw,
// stalls upstream while a transfer is outstanding and produces the MEM/WB payload.
module mem_stage
    import core_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              stall_i,
    input  logic [31:0]       result_i,
    input  logic [31:0]       read_data2_i,
    input  logic [31:0]       cout_i,
    input  logic [1:0]        wb_sel_i,
    input  logic              reg_write_enable_i,
    input  logic              mem_write_enable_i,
    input  logic [4:0]        reg_write_dst_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [31:0]       dmem_wdata_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [31:0]       dmem_rdata_i,
    output logic              mem_busy_o,
    output logic              mem_err_o,
    output logic [31:0]       wb_data_o,
    output logic              reg_write_enable_o,
    output logic [4:0]        reg_write_dst_o,
    output logic              m_valid_o,
    output logic [4:0]        m_dest_reg_o
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    mem_state_t        r_state;
    mem_state_t        w_next_state;
    logic [CNT_W-1:0]  r_tmo_cnt;
    logic              r_is_store;
    logic              r_kill;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [XLEN-1:0]   r_hold_data;
    logic [REG_W-1:0]  r_dst;

    logic              w_is_load;
    logic              w_is_store;
    logic              w_mem_op;
    logic              w_aligned;
    logic              w_timeout;
    logic              w_start;
    logic              w_misalign;
    logic              w_abort;
    logic              w_capture;
    logic              w_kill_set;
    logic              w_wb_load;
    logic              w_wb_bubble;
    logic              w_busy;
    mem_wb_t           w_wb_d;
    mem_wb_t           w_wb_q;

    assign w_is_load  = reg_write_enable_i & (wb_sel_i == WB_MEM);
    assign w_is_store = mem_write_enable_i;
    assign w_mem_op   = w_is_load | w_is_store;
    assign w_aligned  = (result_i[1:0] == 2'b00);
    assign w_timeout  = (r_tmo_cnt >= TMO_LAST);

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state, handshake decisions and MEM/WB register controls.
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_misalign   = 1'b0;
        w_abort      = 1'b0;
        w_capture    = 1'b0;
        w_kill_set   = 1'b0;
        w_wb_load    = 1'b0;
        w_wb_bubble  = 1'b0;
        w_wb_d       = '0;
        w_busy       = 1'b0;

        case (r_state)
            IDLE: begin
                w_busy = w_mem_op & w_aligned & ~flush_i;
                if (!stall_i) begin
                    if (flush_i) begin
                        w_wb_bubble = 1'b1;
                    end else if (w_mem_op) begin
                        w_wb_bubble = 1'b1;
                        if (w_aligned) begin
                            w_start      = 1'b1;
                            w_next_state = REQ;
                        end else begin
                            w_misalign = 1'b1;
                        end
                    end else begin
                        w_wb_load   = 1'b1;
                        w_wb_d.data = alu_wb_data(wb_sel_i, result_i, cout_i);
                        w_wb_d.we   = reg_write_enable_i;
                        w_wb_d.dst  = reg_write_dst_i;
                    end
                end
            end

            REQ: begin
                w_busy = 1'b1;
                if (dmem_gnt_i) begin
                    if (r_is_store) begin
                        w_busy       = 1'b0;
                        w_wb_bubble  = 1'b1;
                        w_next_state = IDLE;
                    end else begin
                        // A flush racing the grant still lets the read finish, but discards it.
                        w_kill_set   = flush_i;
                        w_next_state = WAIT;
                    end
                end else if (flush_i) begin
                    w_wb_bubble  = 1'b1;
                    w_next_state = IDLE;
                end else if (w_timeout) begin
                    w_busy       = 1'b0;
                    w_abort      = 1'b1;
                    w_wb_bubble  = 1'b1;
                    w_next_state = IDLE;
                end
            end

            WAIT: begin
                w_busy     = ~dmem_rvalid_i;
                w_kill_set = flush_i;
                if (dmem_rvalid_i) begin
                    if (r_kill || flush_i) begin
                        w_wb_bubble  = 1'b1;
                        w_next_state = IDLE;
                    end else if (!stall_i) begin
                        w_wb_load    = 1'b1;
                        w_wb_d.data  = dmem_rdata_i;
                        w_wb_d.we    = 1'b1;
                        w_wb_d.dst   = r_dst;
                        w_next_state = IDLE;
                    end else begin
                        w_capture    = 1'b1;
                        w_next_state = HOLD;
                    end
                end else if (w_timeout) begin
                    w_busy       = 1'b0;
                    w_abort      = 1'b1;
                    w_wb_bubble  = 1'b1;
                    w_next_state = IDLE;
                end
            end

            HOLD: begin
                // Busy releases on the cycle the held load retires so upstream steps exactly once.
                w_busy = stall_i;
                if (!stall_i) begin
                    w_wb_load    = 1'b1;
                    w_wb_d.data  = r_hold_data;
                    w_wb_d.we    = 1'b1;
                    w_wb_d.dst   = r_dst;
                    w_next_state = IDLE;
                end
            end

            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Transfer context, timeout counter and error pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tmo_cnt   <= '0;
            r_is_store  <= 1'b0;
            r_kill      <= 1'b0;
            r_err       <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_hold_data <= '0;
            r_dst       <= '0;
        end else begin
            r_err <= w_misalign | w_abort;

            if (w_next_state == IDLE) begin
                r_tmo_cnt <= '0;
            end else if (r_state == REQ || r_state == WAIT) begin
                r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
            end

            if (w_start) begin
                r_is_store <= w_is_store;
                r_addr     <= ADDR_W'(result_i);
                r_wdata    <= read_data2_i;
                r_dst      <= reg_write_dst_i;
                r_kill     <= 1'b0;
            end else if (w_kill_set) begin
                r_kill <= 1'b1;
            end

            if (w_capture) begin
                r_hold_data <= dmem_rdata_i;
            end
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .stall_i  (stall_i),
        .load_i   (w_wb_load),
        .bubble_i (w_wb_bubble),
        .d_i      (w_wb_d),
        .q_o      (w_wb_q)
    );

    assign dmem_req_o         = (r_state == REQ);
    assign dmem_we_o          = (r_state == REQ) & r_is_store;
    assign dmem_addr_o        = r_addr;
    assign dmem_wdata_o       = r_wdata;
    assign mem_busy_o         = w_busy;
    assign mem_err_o          = r_err;
    assign wb_data_o          = w_wb_q.data;
    assign reg_write_enable_o = w_wb_q.we;
    assign reg_write_dst_o    = w_wb_q.dst;
    assign m_valid_o          = w_wb_q.we;
    assign m_dest_reg_o       = w_wb_q.dst;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed handshake scenarios followed by a random op stream
// checked against an in-order transaction model with its own shadow memory.
module tb_mem_stage;
    import core_pkg::*;

    localparam int unsigned TMO   = 8;
    localparam int unsigned N_OPS = 300;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  dst;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        stall;
    logic [31:0] result;
    logic [31:0] rd2;
    logic [31:0] cout;
    logic [1:0]  wb_sel;
    logic        rwe_i;
    logic        mwe_i;
    logic [4:0]  dst_i;
    logic        req;
    logic        dwe;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        busy;
    logic        err;
    logic [31:0] wb_data;
    logic        rwe_o;
    logic [4:0]  dst_o;
    logic        m_valid;
    logic [4:0]  m_dest;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT_CYC(TMO), .ADDR_W(32)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .flush_i            (flush),
        .stall_i            (stall),
        .result_i           (result),
        .read_data2_i       (rd2),
        .cout_i             (cout),
        .wb_sel_i           (wb_sel),
        .reg_write_enable_i (rwe_i),
        .mem_write_enable_i (mwe_i),
        .reg_write_dst_i    (dst_i),
        .dmem_req_o         (req),
        .dmem_we_o          (dwe),
        .dmem_addr_o        (addr),
        .dmem_wdata_o       (wdata),
        .dmem_gnt_i         (gnt),
        .dmem_rvalid_i      (rvalid),
        .dmem_rdata_i       (rdata),
        .mem_busy_o         (busy),
        .mem_err_o          (err),
        .wb_data_o          (wb_data),
        .reg_write_enable_o (rwe_o),
        .reg_write_dst_o    (dst_o),
        .m_valid_o          (m_valid),
        .m_dest_reg_o       (m_dest)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic we, input logic mwe, input logic [1:0] sel,
                          input logic [31:0] res, input logic [31:0] wd,
                          input logic [31:0] co, input logic [4:0] d);
        rwe_i  = we;
        mwe_i  = mwe;
        wb_sel = sel;
        result = res;
        rd2    = wd;
        cout   = co;
        dst_i  = d;
    endtask

    task automatic idle_op();
        set_op(1'b0, 1'b0, WB_ALU, 32'd0, 32'd0, 32'd0, 5'd0);
    endtask

    logic [31:0] ref_mem [16];
    logic [31:0] dev_mem [16];
    exp_t        exp_q [$];

    initial begin
        exp_t        e;
        int          issued, exp_err, got_err, drain, cyc;
        int          gnt_wait, rd_wait, kind;
        logic        advance, req_seen, rd_pend, cur_store;
        logic [31:0] cur_addr, cur_wdata, rd_val, val, co;
        logic [3:0]  idx;
        logic [4:0]  d;
        logic [1:0]  sel;
        logic        we;

        rst = 1'b1; flush = 1'b0; stall = 1'b0;
        gnt = 1'b0; rvalid = 1'b0; rdata = '0;
        idle_op();
        tick(); tick();
        rst = 1'b0; #1;
        chk("rst_wb_data", wb_data, 0);
        chk("rst_we", rwe_o, 0);
        chk("rst_dst", dst_o, 0);
        chk("rst_req", req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_mvalid", m_valid, 0);
        chk("rst_addr", addr, 0);

        // non-mem ops: ALU, TPU, select 3, flushed
        set_op(1'b1, 1'b0, WB_ALU, 32'h1234, 32'h0, 32'h0, 5'd5); #1;
        chk("alu_busy", busy, 0);
        tick();
        set_op(1'b1, 1'b0, WB_TPU, 32'h1111, 32'h0, 32'hA5A5_0F0F, 5'd9); #1;
        chk("alu_data", wb_data, 32'h1234);
        chk("alu_we", rwe_o, 1);
        chk("alu_mdest", m_dest, 5);
        chk("alu_mvalid", m_valid, 1);
        tick();
        set_op(1'b1, 1'b0, 2'd3, 32'h2222, 32'h0, 32'h0, 5'd10); #1;
        chk("tpu_data", wb_data, 32'hA5A5_0F0F);
        chk("tpu_dst", dst_o, 9);
        tick();
        flush = 1'b1;
        set_op(1'b1, 1'b0, WB_ALU, 32'h3333, 32'h0, 32'h0, 5'd11); #1;
        chk("sel3_data", wb_data, 0);
        chk("sel3_dst", dst_o, 10);
        tick();
        flush = 1'b0; idle_op(); #1;
        chk("flush_we", rwe_o, 0);

        // load: grant on 3rd request cycle, rvalid on 3rd wait cycle
        set_op(1'b1, 1'b0, WB_MEM, 32'h100, 32'h0, 32'h0, 5'd7); #1;
        chk("ld_busy_idle", busy, 1);
        chk("ld_req_idle", req, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            gnt = (i == 2); #1;
            chk("ld_req", req, 1);
            chk("ld_addr", addr, 32'h100);
            chk("ld_dwe", dwe, 0);
            chk("ld_busy_req", busy, 1);
        end
        tick();
        gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rvalid = (i == 2);
            rdata  = (i == 2) ? 32'hDEAD_BEEF : 32'h0; #1;
            chk("ld_req_wait", req, 0);
            chk("ld_busy_wait", busy, (i == 2) ? 32'd0 : 32'd1);
            chk("ld_bubble", rwe_o, 0);
            tick();
        end
        rvalid = 1'b0; idle_op(); #1;
        chk("ld_data", wb_data, 32'hDEAD_BEEF);
        chk("ld_we", rwe_o, 1);
        chk("ld_dst", dst_o, 7);

        // store with immediate grant
        set_op(1'b0, 1'b1, WB_ALU, 32'h40, 32'hCAFE, 32'h0, 5'd0); #1;
        chk("st_busy_idle", busy, 1);
        tick();
        gnt = 1'b1; #1;
        chk("st_req", req, 1);
        chk("st_dwe", dwe, 1);
        chk("st_addr", addr, 32'h40);
        chk("st_wdata", wdata, 32'hCAFE);
        chk("st_busy_gnt", busy, 0);
        tick();
        gnt = 1'b0; idle_op(); #1;
        chk("st_req_done", req, 0);
        chk("st_we", rwe_o, 0);

        // misaligned load
        set_op(1'b1, 1'b0, WB_MEM, 32'h102, 32'h0, 32'h0, 5'd3); #1;
        chk("mis_busy", busy, 0);
        chk("mis_req", req, 0);
        tick();
        idle_op(); #1;
        chk("mis_err", err, 1);
        chk("mis_req_after", req, 0);
        chk("mis_we", rwe_o, 0);
        tick(); #1;
        chk("mis_err_pulse", err, 0);

        // timeout: grant never arrives
        set_op(1'b1, 1'b0, WB_MEM, 32'h80, 32'h0, 32'h0, 5'd6); #1;
        for (int i = 0; i < 8; i++) begin
            tick(); #1;
            chk("to_req", req, 1);
            chk("to_err_early", err, 0);
            if (i == 7) chk("to_busy_drop", busy, 0);
        end
        tick();
        idle_op(); #1;
        chk("to_err", err, 1);
        chk("to_req_off", req, 0);
        chk("to_busy", busy, 0);
        chk("to_we", rwe_o, 0);

        // rvalid under a 4-cycle stall
        tick();
        set_op(1'b1, 1'b0, WB_MEM, 32'h10, 32'h0, 32'h0, 5'd12); #1;
        tick();
        gnt = 1'b1; #1;
        tick();
        gnt = 1'b0;
        rvalid = 1'b1; rdata = 32'h1357_2468; stall = 1'b1; #1;
        chk("stl_busy_rv", busy, 0);
        tick();
        rvalid = 1'b0; rdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stl_frozen", rwe_o, 0);
            chk("stl_busy_hold", busy, 1);
            tick();
        end
        stall = 1'b0; #1;
        tick();
        idle_op(); #1;
        chk("stl_data", wb_data, 32'h1357_2468);
        chk("stl_we", rwe_o, 1);
        chk("stl_dst", dst_o, 12);

        // reset while waiting for read data; late rvalid must be ignored
        set_op(1'b1, 1'b0, WB_MEM, 32'h20, 32'h0, 32'h0, 5'd4); #1;
        tick();
        gnt = 1'b1; #1;
        tick();
        gnt = 1'b0; rst = 1'b1; #1;
        tick();
        rst = 1'b0; idle_op(); #1;
        chk("rw_req", req, 0);
        chk("rw_we", rwe_o, 0);
        chk("rw_data", wb_data, 0);
        chk("rw_busy", busy, 0);
        chk("rw_err", err, 0);
        rvalid = 1'b1; rdata = 32'hBAD0_BAD0; #1;
        tick();
        rvalid = 1'b0; rdata = 32'h0; #1;
        chk("rw_late_we", rwe_o, 0);
        chk("rw_late_data", wb_data, 0);

        // flush cancels an ungranted request
        set_op(1'b1, 1'b0, WB_MEM, 32'h30, 32'h0, 32'h0, 5'd8); #1;
        tick();
        flush = 1'b1; #1;
        chk("fl_req", req, 1);
        tick();
        flush = 1'b0; idle_op(); #1;
        chk("fl_req_off", req, 0);
        chk("fl_we", rwe_o, 0);

        // random op stream against the transaction model
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = $urandom;
            dev_mem[i] = ref_mem[i];
        end
        issued = 0; exp_err = 0; got_err = 0; drain = 0; cyc = 0;
        advance = 1'b1; req_seen = 1'b0; rd_pend = 1'b0;
        gnt_wait = 0; rd_wait = 0; rd_val = '0;
        cur_store = 1'b0; cur_addr = '0; cur_wdata = '0;
        while (cyc < 6000 && drain < 10) begin
            cyc++;
            if (rwe_o) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_unexp_wb", {27'd0, dst_o}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("rnd_wb_data", wb_data, e.data);
                    chk("rnd_wb_dst", {27'd0, dst_o}, {27'd0, e.dst});
                end
            end
            if (err) got_err++;

            if (advance) begin
                if (issued < int'(N_OPS)) begin
                    issued++;
                    kind = int'($urandom_range(0, 5));
                    idx  = 4'($urandom_range(0, 15));
                    d    = 5'($urandom_range(1, 31));
                    val  = $urandom;
                    co   = $urandom;
                    case (kind)
                        0, 1: begin
                            case ($urandom_range(0, 2))
                                0:       sel = WB_ALU;
                                1:       sel = WB_TPU;
                                default: sel = 2'd3;
                            endcase
                            we = 1'($urandom_range(0, 1));
                            set_op(we, 1'b0, sel, val, $urandom, co, d);
                            if (we) begin
                                e.data = (sel == WB_ALU) ? val : (sel == WB_TPU) ? co : 32'd0;
                                e.dst  = d;
                                exp_q.push_back(e);
                            end
                        end
                        2, 3: begin
                            cur_addr  = {26'd0, idx, 2'b00};
                            cur_store = 1'b0;
                            set_op(1'b1, 1'b0, WB_MEM, cur_addr, $urandom, co, d);
                            e.data = ref_mem[idx];
                            e.dst  = d;
                            exp_q.push_back(e);
                        end
                        4: begin
                            cur_addr  = {26'd0, idx, 2'b00};
                            cur_store = 1'b1;
                            cur_wdata = val;
                            set_op(1'b0, 1'b1, WB_ALU, cur_addr, val, co, d);
                            ref_mem[idx] = val;
                        end
                        default: begin
                            cur_addr = {26'd0, idx, 2'b00} | 32'($urandom_range(1, 3));
                            if ($urandom_range(0, 1) == 0)
                                set_op(1'b1, 1'b0, WB_MEM, cur_addr, val, co, d);
                            else
                                set_op(1'b0, 1'b1, WB_ALU, cur_addr, val, co, d);
                            exp_err++;
                        end
                    endcase
                end else begin
                    idle_op();
                end
            end
            if (issued == int'(N_OPS) && exp_q.size() == 0 && !busy) drain++;

            gnt = 1'b0; rvalid = 1'b0; rdata = '0;
            if (rd_pend) begin
                if (rd_wait == 0) begin
                    rvalid  = 1'b1;
                    rdata   = rd_val;
                    rd_pend = 1'b0;
                end else begin
                    rd_wait--;
                end
            end
            if (req) begin
                if (!req_seen) begin
                    req_seen = 1'b1;
                    gnt_wait = int'($urandom_range(0, 2));
                end
                if (gnt_wait == 0) begin
                    gnt      = 1'b1;
                    req_seen = 1'b0;
                    chk("rnd_addr", addr, cur_addr);
                    chk("rnd_dwe", {31'd0, dwe}, {31'd0, cur_store});
                    if (dwe) begin
                        chk("rnd_wdata", wdata, cur_wdata);
                        dev_mem[addr[5:2]] = wdata;
                    end else begin
                        rd_pend = 1'b1;
                        rd_wait = int'($urandom_range(0, 2));
                        rd_val  = dev_mem[addr[5:2]];
                    end
                end else begin
                    gnt_wait--;
                end
            end
            #1;
            advance = !busy;
            tick();
        end
        gnt = 1'b0; rvalid = 1'b0;
        chk("rnd_issued", 32'(issued), 32'(N_OPS));
        chk("rnd_drain", 32'(exp_q.size()), 32'd0);
        chk("rnd_err_cnt", 32'(got_err), 32'(exp_err));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline MEM stage, directly downstream of `execute`. It consumes the execute outputs: ALU result, store data, TPU accumulator word, write-back select and control.
- It runs a variable-latency request/grant/rvalid handshake to data memory for lw/sw and stalls upstream while a transfer is outstanding.
- It produces the registered MEM/WB payload plus forwarding info for the hazard unit.

Parameters:
- TIMEOUT_CYC, 255: max cycles spent in REQ+WAIT before the transfer is aborted.
- ADDR_W, 32: data-memory address width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- flush_i  in  1  squash the op at input / cancel an ungranted request
- stall_i  in  1  freeze the MEM/WB output register
- result_i  in  32  ALU result; memory address for lw/sw
- read_data2_i  in  32  store data
- cout_i  in  32  TPU accumulator word (racc)
- wb_sel_i  in  2  0=ALU, 1=MEM, 2=TPU
- reg_write_enable_i  in  1  instruction writes a register
- mem_write_enable_i  in  1  store
- reg_write_dst_i  in  5  destination register
- dmem_req_o  out  1  memory request
- dmem_we_o  out  1  request is a write
- dmem_addr_o  out  ADDR_W  word-aligned byte address
- dmem_wdata_o  out  32  store data
- dmem_gnt_i  in  1  request accepted
- dmem_rvalid_i  in  1  read data valid
- dmem_rdata_i  in  32  read data
- mem_busy_o  out  1  stall request to upstream stages
- mem_err_o  out  1  one-cycle pulse on misaligned access or timeout
- wb_data_o  out  32  write-back data
- reg_write_enable_o  out  1  write-back enable
- reg_write_dst_o  out  5  write-back destination
- m_valid_o  out  1  output register holds a reg-writing instruction
- m_dest_reg_o  out  5  forwarding destination (= reg_write_dst_o)

Behaviour:
- Reset:
  - State IDLE; timeout counter 0.
  - All outputs 0, including dmem_req_o and the MEM/WB register.
- Op classes:
  - load = reg_write_enable_i & wb_sel_i==1.
  - store = mem_write_enable_i.
  - mem op = load | store.
  - Anything else is non-mem.
- Non-mem path, IDLE, !stall_i:
  - Registered next cycle, latency 1.
  - wb_data_o = result_i if wb_sel 0; cout_i if wb_sel 2; 0 if wb_sel 3.
  - reg_write_enable_o and reg_write_dst_o are copied from the inputs.
- flush_i in IDLE: output register loads a bubble (all 0).
- stall_i in IDLE: output register holds its value; no new op is accepted.
- FSM states: IDLE, REQ, WAIT, HOLD.
  - IDLE → REQ: mem op present, !flush_i, !stall_i, address aligned. The cycle, op and address are latched; output register loads a bubble.
  - Misaligned mem op in IDLE (result_i[1:0]!=0):
    - No request is issued; mem_err_o pulses the next cycle.
    - Output register loads a bubble; op is treated as complete.
  - REQ:
    - dmem_req_o=1; dmem_we_o = latched store flag; dmem_addr_o and dmem_wdata_o are stable until grant.
    - Store & dmem_gnt_i → IDLE; output register loads a bubble.
    - Load & dmem_gnt_i → WAIT.
    - flush_i & !dmem_gnt_i → IDLE; request drops; no write-back.
  - WAIT: dmem_req_o=0.
    - dmem_rvalid_i & !stall_i → IDLE; output register loads {dmem_rdata_i, 1, dst}.
    - dmem_rvalid_i & stall_i → HOLD; data captured in the holding register.
    - flush_i in WAIT: the response is still awaited and then discarded (write-back suppressed).
  - HOLD: on !stall_i, the output register loads the held data → IDLE.
- Timeout:
  - Counter increments each cycle in REQ/WAIT and clears on entering IDLE.
  - Reaching TIMEOUT_CYC → mem_err_o pulse, abort to IDLE, bubble written.
- mem_busy_o (combinational) is 1 when:
  - IDLE with an aligned mem op & !flush_i, or
  - REQ unless (store & gnt), or
  - WAIT unless rvalid, or
  - HOLD.
- mem_busy_o drops in the completion cycle so upstream advances on that edge.
- Minimum load latency: 3 cycles (IDLE→REQ with gnt→WAIT with rvalid); minimum store latency: 2.
- m_valid_o = reg_write_enable_o; no forwarding ever comes from an in-flight load.
- rst_i mid-transfer: immediate return to IDLE, dmem_req_o=0 next cycle; a late rvalid in IDLE is ignored.

Decomposition:
- Package core_pkg holds:
  - wb_sel constants WB_ALU=0, WB_MEM=1, WB_TPU=2;
  - the mem_state_t enum {IDLE, REQ, WAIT, HOLD};
  - a mem_wb_t struct {data, we, dst}.
- One sub-module, mem_wb_reg: the MEM/WB payload register with stall/flush/load controls.

Test Plan:
- Non-mem op: add, result_i=32'h1234, dst=5 → next cycle wb_data_o=32'h1234, reg_write_enable_o=1, m_dest_reg_o=5, mem_busy_o=0.
- Load: addr=32'h100, gnt after 2 cycles, rvalid 3 cycles later with rdata=32'hDEADBEEF, dst=7.
  - dmem_req_o high exactly until gnt; mem_busy_o high until the rvalid cycle.
  - wb_data_o=32'hDEADBEEF on the following cycle.
- Store: addr=32'h40, wdata=32'hCAFE, immediate gnt.
  - dmem_we_o=1, one request cycle, reg_write_enable_o=0, busy for 1 cycle.
- Misaligned: lw with addr=32'h102.
  - No dmem_req_o; mem_err_o pulses 1 cycle; reg_write_enable_o=0.
- Timeout: TIMEOUT_CYC=8, gnt never asserted.
  - mem_err_o after 8 REQ cycles, busy drops, dmem_req_o=0.
- Stall/reset: rvalid with stall_i=1 for 4 cycles → data appears 1 cycle after stall drops.
  - Separately, rst_i asserted in WAIT → all outputs 0 next cycle and a later rvalid is ignored.
